adder_functional_unit: RTL and testbench
========================================

Name: adder_functional_unit

Overview:
- Execution end of the adder reservation-station dispatch interface: accepts one ready ADD/SUB instruction with its tag and both operand values, computes over a fixed multi-cycle latency, then presents the result with its tag and instruction on a completion port.
- Holds the result until the completion bus acknowledges it.
- Reports availability back to the reservation station so a new dispatch is accepted only when the unit is idle.

Parameters:
- DATA_W, 16, operand/result width.
- TAG_W, 3, reservation-station entry tag width.
- INST_W, 16, instruction word width.
- LATENCY, 3, cycles from accepted dispatch to first cdb_valid; legal range 1..15.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  dispatch request from reservation station.
- issue_inst  in  INST_W  instruction: [3:0] opcode, [6:4] Rx, [9:7] Ry, [12:10] Rz.
- issue_tag  in  TAG_W  reservation-station entry number.
- op_a  in  DATA_W  value of Ry (first operand).
- op_b  in  DATA_W  value of Rx (second operand).
- issue_ready  out  1  unit idle; a dispatch is accepted this cycle if issue_valid.
- cdb_valid  out  1  result available.
- cdb_tag  out  TAG_W  tag of the completing instruction.
- cdb_inst  out  INST_W  completing instruction word.
- cdb_data  out  DATA_W  result.
- cdb_illegal  out  1  completing opcode was not an adder opcode.
- cdb_ack  in  1  completion bus accepted the result.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, issue_ready=1, cdb_valid=0, cdb_tag=0, cdb_inst=0, cdb_data=0, cdb_illegal=0.
- Any operation in flight at reset is dropped; no completion is produced for it.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - issue_ready=1.
  - On an edge with issue_valid=1, latch tag, inst, op_a and op_b; compute the result; load counter=LATENCY-1.
  - Next state is DONE if LATENCY=1, else EXEC.
- EXEC:
  - issue_ready=0; counter decrements each edge.
  - When counter==1 at an edge, go to DONE.
  - cdb_valid rises exactly LATENCY edges after the accepting edge.
- DONE:
  - issue_ready=0; cdb_valid=1; cdb_tag, cdb_inst, cdb_data and cdb_illegal are stable.
  - On an edge with cdb_ack=1, go to IDLE, clear cdb_valid, and raise issue_ready the next cycle.
  - Outputs hold indefinitely while cdb_ack=0.
- Back-to-back: minimum issue-to-issue spacing is LATENCY+1 cycles, given immediate ack.
- cdb_ack outside DONE is ignored. issue_valid while issue_ready=0 is ignored; the reservation station must retry.
- Arithmetic:
  - Opcode 4'b0000 or 4'b0100: result = op_a + op_b.
  - Opcode 4'b0001 or 4'b0101: result = op_a - op_b.
  - Both are two's complement modulo 2^DATA_W; carry and borrow are discarded.
- Any other opcode: still accepted and completed with normal latency, cdb_data=0, cdb_illegal=1.
- Result outputs keep their last value after ack; only cdb_valid qualifies them.

Optional Feature:
- Macro: ADDER_FU_OVERFLOW_EN.
- Defined:
  - Extra output cdb_overflow (1 bit), valid with cdb_valid.
  - Set on signed overflow: ADD, operands of equal sign and result of opposite sign; SUB, operands of different sign and result sign differing from op_a.
  - Reset value 0; forced 0 on illegal opcodes.
- Undefined: port absent; no overflow logic.

Decomposition:
- Package adder_fu_pkg:
  - opcode localparams OP_ADD=4'b0000, OP_SUB=4'b0001, OP_ADDB=4'b0100, OP_SUBB=4'b0101;
  - FSM state encoding IDLE/EXEC/DONE;
  - instruction field bit positions.
- Sub-module adder_fu_alu: combinational opcode decode plus add/sub; outputs result, illegal and (under macro) overflow. The top level holds the FSM, counter and output registers.

Test Plan:
- Reset, then issue ADD tag=3, op_a=16'h0005, op_b=16'h0007, LATENCY=3 -> cdb_valid rises 3 edges later; cdb_tag=3, cdb_data=16'h000C, cdb_illegal=0; issue_ready low until the edge after ack.
- SUB op_a=16'h0002, op_b=16'h0005 with ack delayed 4 cycles -> cdb_data=16'hFFFD held stable all 4 cycles; issue_valid pulses during that time are ignored.
- ADD op_a=16'hFFFF, op_b=16'h0001 -> cdb_data=16'h0000. With ADDER_FU_OVERFLOW_EN, ADD op_a=16'h7FFF, op_b=16'h0001 -> cdb_data=16'h8000, cdb_overflow=1.
- Opcode 4'b0010, tag=6 -> completes after LATENCY with cdb_illegal=1, cdb_data=0, cdb_tag=6.
- Reset asserted mid-EXEC -> outputs go to reset values immediately; no cdb_valid follows; a new issue after deassertion completes normally.
- LATENCY=1 build: issue at edge N, cdb_valid at N+1; ack held high continuously -> unit re-accepts every 2 cycles; tags 1,2,3 complete in order.

Source files
------------

// File: rtl/adder_fu_pkg.sv
// Shared definitions for the adder functional unit.
//   - adder opcodes (ADD/SUB and their B-variants)
//   - FSM state encoding
//   - instruction field bit positions
// Optional feature macro used elsewhere: ADDER_FU_OVERFLOW_EN
package adder_fu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADDB = 4'b0100;
    localparam logic [3:0] OP_SUBB = 4'b0101;

    // Instruction word fields: [3:0] opcode, [6:4] Rx, [9:7] Ry, [12:10] Rz
    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_MSB = 3;
    localparam int unsigned RX_LSB  = 4;
    localparam int unsigned RX_MSB  = 6;
    localparam int unsigned RY_LSB  = 7;
    localparam int unsigned RY_MSB  = 9;
    localparam int unsigned RZ_LSB  = 10;
    localparam int unsigned RZ_MSB  = 12;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } fu_state_e;

endpackage

// File: rtl/adder_functional_unit_if.sv
// Dispatch + completion bus between reservation station and adder unit.
//   master: reservation station / completion bus side (drives issue_*, op_*, cdb_ack)
//   slave : functional unit (drives issue_ready, cdb_*)
// With ADDER_FU_OVERFLOW_EN defined an extra cdb_overflow signal is carried.
interface adder_functional_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned INST_W = 16
);
    logic              issue_valid;
    logic [INST_W-1:0] issue_inst;
    logic [TAG_W-1:0]  issue_tag;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              issue_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [INST_W-1:0] cdb_inst;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_illegal;
    logic              cdb_ack;
`ifdef ADDER_FU_OVERFLOW_EN
    logic              cdb_overflow;

    modport master (
        output issue_valid, issue_inst, issue_tag, op_a, op_b, cdb_ack,
        input  issue_ready, cdb_valid, cdb_tag, cdb_inst, cdb_data, cdb_illegal, cdb_overflow
    );
    modport slave (
        input  issue_valid, issue_inst, issue_tag, op_a, op_b, cdb_ack,
        output issue_ready, cdb_valid, cdb_tag, cdb_inst, cdb_data, cdb_illegal, cdb_overflow
    );
`else
    modport master (
        output issue_valid, issue_inst, issue_tag, op_a, op_b, cdb_ack,
        input  issue_ready, cdb_valid, cdb_tag, cdb_inst, cdb_data, cdb_illegal
    );
    modport slave (
        input  issue_valid, issue_inst, issue_tag, op_a, op_b, cdb_ack,
        output issue_ready, cdb_valid, cdb_tag, cdb_inst, cdb_data, cdb_illegal
    );
`endif
endinterface

// File: rtl/adder_fu_alu.sv
// Combinational opcode decode and add/subtract.
//   opcode  in : instruction opcode field
//   op_a    in : first operand (Ry)
//   op_b    in : second operand (Rx)
//   result  out: op_a +/- op_b modulo 2^DATA_W, 0 for non-adder opcodes
//   illegal out: opcode is not an adder opcode
//   overflow out (ADDER_FU_OVERFLOW_EN only): signed overflow, 0 when illegal
module adder_fu_alu
    import adder_fu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] result,
`ifdef ADDER_FU_OVERFLOW_EN
    output logic              overflow,
`endif
    output logic              illegal
);

    logic a_s, b_s, r_s;
    assign a_s = op_a[DATA_W-1];
    assign b_s = op_b[DATA_W-1];
    assign r_s = result[DATA_W-1];

    always_comb begin
        result  = '0;
        illegal = 1'b0;
`ifdef ADDER_FU_OVERFLOW_EN
        overflow = 1'b0;
`endif
        case (opcode)
            OP_ADD, OP_ADDB: begin
                result = op_a + op_b;
`ifdef ADDER_FU_OVERFLOW_EN
                overflow = (a_s == b_s) && (r_s != a_s);
`endif
            end
            OP_SUB, OP_SUBB: begin
                result = op_a - op_b;
`ifdef ADDER_FU_OVERFLOW_EN
                overflow = (a_s != b_s) && (r_s != a_s);
`endif
            end
            default: illegal = 1'b1;
        endcase
    end

`ifndef ADDER_FU_OVERFLOW_EN
    // Sign bits only feed the overflow logic.
    logic unused_signs;
    assign unused_signs = a_s ^ b_s ^ r_s;
`endif

endmodule

// File: rtl/adder_functional_unit.sv
// Adder functional unit: accepts one ADD/SUB dispatch when idle, completes it
// LATENCY cycles later on the completion port and holds it until cdb_ack.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : adder_functional_unit_if.slave (issue_* in, issue_ready out,
//              cdb_* out, cdb_ack in)
// Optional macro ADDER_FU_OVERFLOW_EN adds cdb_overflow.
module adder_functional_unit
    import adder_fu_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned INST_W  = 16,
    parameter int unsigned LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    adder_functional_unit_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    fu_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_illegal;
`ifdef ADDER_FU_OVERFLOW_EN
    logic              alu_overflow;
    logic              ovf_q, ovf_d;
`endif

    // Result is computed from the dispatch inputs and captured on acceptance.
    adder_fu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode   (bus.issue_inst[OPC_MSB:OPC_LSB]),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .result   (alu_result),
`ifdef ADDER_FU_OVERFLOW_EN
        .overflow (alu_overflow),
`endif
        .illegal  (alu_illegal)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        inst_d    = inst_q;
        data_d    = data_q;
        illegal_d = illegal_q;
`ifdef ADDER_FU_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.issue_valid) begin
                    tag_d     = bus.issue_tag;
                    inst_d    = bus.issue_inst;
                    data_d    = alu_result;
                    illegal_d = alu_illegal;
`ifdef ADDER_FU_OVERFLOW_EN
                    ovf_d     = alu_overflow;
`endif
                    cnt_d     = CNT_INIT;
                    state_d   = (LATENCY == 1) ? StDone : StExec;
                end
            end
            StExec: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.cdb_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            tag_q     <= '0;
            inst_q    <= '0;
            data_q    <= '0;
            illegal_q <= 1'b0;
`ifdef ADDER_FU_OVERFLOW_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            inst_q    <= inst_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
`ifdef ADDER_FU_OVERFLOW_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign bus.issue_ready  = (state_q == StIdle);
    assign bus.cdb_valid    = (state_q == StDone);
    assign bus.cdb_tag      = tag_q;
    assign bus.cdb_inst     = inst_q;
    assign bus.cdb_data     = data_q;
    assign bus.cdb_illegal  = illegal_q;
`ifdef ADDER_FU_OVERFLOW_EN
    assign bus.cdb_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_adder_functional_unit.sv
// Directed bench: LATENCY=3 unit (u_dut) for the main cases and a LATENCY=1
// unit (u_dut1) for back-to-back throughput with ack held high.
module tb_adder_functional_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_functional_unit_if #(.DATA_W(16), .TAG_W(3), .INST_W(16)) bus ();
    adder_functional_unit_if #(.DATA_W(16), .TAG_W(3), .INST_W(16)) bus1 ();

    adder_functional_unit #(
        .DATA_W (16), .TAG_W (3), .INST_W (16), .LATENCY (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    adder_functional_unit #(
        .DATA_W (16), .TAG_W (3), .INST_W (16), .LATENCY (1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present one dispatch and count edges (accepting edge included) until cdb_valid.
    task automatic run_op(input logic [2:0] tag, input logic [15:0] inst,
                          input logic [15:0] a, input logic [15:0] b, output int lat);
        bus.issue_valid = 1'b1;
        bus.issue_tag   = tag;
        bus.issue_inst  = inst;
        bus.op_a        = a;
        bus.op_b        = b;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus.issue_valid = 1'b0;
            lat++;
            if (bus.cdb_valid) break;
        end
    endtask

    task automatic ack_once();
        bus.cdb_ack = 1'b1;
        @(posedge clk); #1;
        bus.cdb_ack = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        int done;
        logic [2:0] t;
        bus.issue_valid  = 1'b0; bus.issue_tag  = '0; bus.issue_inst  = '0;
        bus.op_a         = '0;   bus.op_b       = '0; bus.cdb_ack     = 1'b0;
        bus1.issue_valid = 1'b0; bus1.issue_tag = '0; bus1.issue_inst = '0;
        bus1.op_a        = '0;   bus1.op_b      = '0; bus1.cdb_ack    = 1'b0;

        // Reset values
        #12;
        check("rst_ready", bus.issue_ready, 1);
        check("rst_valid", bus.cdb_valid, 0);
        check("rst_tag",   bus.cdb_tag, 0);
        check("rst_inst",  bus.cdb_inst, 0);
        check("rst_data",  bus.cdb_data, 0);
        check("rst_ill",   bus.cdb_illegal, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD 5 + 7, tag 3
        run_op(3'd3, 16'h0000, 16'h0005, 16'h0007, lat);
        check("add_lat",   lat, 3);
        check("add_tag",   bus.cdb_tag, 3);
        check("add_data",  bus.cdb_data, 16'h000C);
        check("add_ill",   bus.cdb_illegal, 0);
        check("add_inst",  bus.cdb_inst, 16'h0000);
        check("add_rdy_lo", bus.issue_ready, 0);
`ifdef ADDER_FU_OVERFLOW_EN
        check("add_ovf",   bus.cdb_overflow, 0);
`endif
        ack_once();
        check("add_vld_off", bus.cdb_valid, 0);
        check("add_rdy_hi",  bus.issue_ready, 1);
        check("add_hold",    bus.cdb_data, 16'h000C);

        // SUB 2 - 5, ack delayed 4 cycles with stray issue pulses
        run_op(3'd5, 16'h0001, 16'h0002, 16'h0005, lat);
        check("sub_lat", lat, 3);
        for (int i = 0; i < 4; i++) begin
            bus.issue_valid = (i % 2 == 0);
            bus.issue_tag   = 3'd7;
            bus.op_a        = 16'hFFFF;
            @(posedge clk); #1;
            check("sub_hold_vld",  bus.cdb_valid, 1);
            check("sub_hold_data", bus.cdb_data, 16'hFFFD);
            check("sub_hold_tag",  bus.cdb_tag, 5);
        end
        bus.issue_valid = 1'b0;
        ack_once();
        check("sub_vld_off", bus.cdb_valid, 0);
        check("sub_idle",    bus.issue_ready, 1);

        // ADDB 0xFFFF + 1 wraps to 0
        run_op(3'd2, 16'h0004, 16'hFFFF, 16'h0001, lat);
        check("wrap_data", bus.cdb_data, 16'h0000);
        check("wrap_tag",  bus.cdb_tag, 2);
`ifdef ADDER_FU_OVERFLOW_EN
        check("wrap_ovf",  bus.cdb_overflow, 0);
        ack_once();
        run_op(3'd1, 16'h0000, 16'h7FFF, 16'h0001, lat);
        check("ovf_data",  bus.cdb_data, 16'h8000);
        check("ovf_flag",  bus.cdb_overflow, 1);
`endif
        ack_once();

        // Illegal opcode 0010, tag 6
        run_op(3'd6, 16'h0002, 16'h0005, 16'h0007, lat);
        check("ill_lat",  lat, 3);
        check("ill_flag", bus.cdb_illegal, 1);
        check("ill_data", bus.cdb_data, 0);
        check("ill_tag",  bus.cdb_tag, 6);
`ifdef ADDER_FU_OVERFLOW_EN
        check("ill_ovf",  bus.cdb_overflow, 0);
`endif
        ack_once();

        // Reset mid-EXEC
        bus.issue_valid = 1'b1; bus.issue_tag = 3'd4; bus.issue_inst = 16'h0000;
        bus.op_a = 16'h0011; bus.op_b = 16'h0022;
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        check("mid_ready", bus.issue_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", bus.issue_ready, 1);
        check("mid_rst_valid", bus.cdb_valid, 0);
        check("mid_rst_tag",   bus.cdb_tag, 0);
        check("mid_rst_data",  bus.cdb_data, 0);
        @(posedge clk); #3 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.cdb_valid) seen++;
        end
        check("mid_no_cmpl", seen, 0);
        run_op(3'd1, 16'h0005, 16'h0010, 16'h0001, lat);
        check("post_lat",  lat, 3);
        check("post_data", bus.cdb_data, 16'h000F);
        check("post_tag",  bus.cdb_tag, 1);
        ack_once();

        // LATENCY=1 unit: ack held, tags 1..3 back to back, completions 2 cycles apart
        bus1.cdb_ack     = 1'b1;
        bus1.issue_valid = 1'b1;
        bus1.issue_inst  = 16'h0000;
        t = 3'd1;
        bus1.issue_tag = t; bus1.op_a = 16'(t); bus1.op_b = 16'h0001;
        done = 0;
        for (int i = 0; i < 12 && done < 3; i++) begin
            logic acc;
            acc = bus1.issue_ready && bus1.issue_valid;
            @(posedge clk); #1;
            if (bus1.cdb_valid) begin
                check("b2b_cycle", i, 2 * done);
                check("b2b_tag",   bus1.cdb_tag, done + 1);
                check("b2b_data",  bus1.cdb_data, done + 2);
                done++;
            end
            if (acc) begin
                if (t == 3'd3) begin
                    bus1.issue_valid = 1'b0;
                end else begin
                    t = t + 3'd1;
                    bus1.issue_tag = t; bus1.op_a = 16'(t);
                end
            end
        end
        check("b2b_count", done, 3);
        bus1.cdb_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
